// File: rtl/arb_pkg.sv
// Shared types for the arbiter client controller.
// Client state encoding and a small popcount helper.
package arb_pkg;

  localparam int N_CLIENTS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/arb_client_fsm.sv
// One client handshake: IDLE/WAIT/GRANT/RELEASE with wait
// counter and sticky starve bit; outputs are registered.
module arb_client_fsm
  import arb_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic done_i,
  input  logic g_i,
  input  logic multi_i,
  output logic arb_x_o,
  output logic grant_o,
  output logic starve_o,
  output logic idle_o
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q, starve_d;
  logic             arb_x_q, grant_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q != CMAX) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CMAX) starve_d = 1'b1;
        if (g_i && !multi_i) state_d = GRANT;
      end
      GRANT: begin
        if (done_i) state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for the arbiter to drop its grant (RTZ).
        if (!g_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= 1'b0;
      arb_x_q  <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      arb_x_q  <= (state_d == WAIT) || (state_d == GRANT);
      grant_q  <= (state_d == GRANT);
    end
  end

  assign arb_x_o  = arb_x_q;
  assign grant_o  = grant_q;
  assign starve_o = starve_q;
  assign idle_o   = (state_q == IDLE);

endmodule

// File: rtl/arb_client_ctrl.sv
// Client-side controller for a 4-way mutex arbiter: grant
// synchroniser, multi/spurious grant checks and client FSMs.
module arb_client_ctrl
  import arb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_MAX    = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CLIENTS-1:0] req_in,
  input  logic [N_CLIENTS-1:0] done_in,
  output logic [N_CLIENTS-1:0] grant_out,
  output logic [N_CLIENTS-1:0] arb_x,
  input  logic [N_CLIENTS-1:0] arb_y,
  output logic                 err_multi,
  output logic                 err_spur,
  output logic [N_CLIENTS-1:0] starve
);

  logic [N_CLIENTS-1:0] sync_q [SYNC_STAGES];
  logic [N_CLIENTS-1:0] g;
  logic [N_CLIENTS-1:0] idle;
  logic                 multi;
  logic                 spur;
  logic                 err_multi_q, err_spur_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= arb_y;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign g     = sync_q[SYNC_STAGES-1];
  assign multi = popcnt4(g) > 3'd1;
  assign spur  = |(g & idle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_multi_q <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      err_multi_q <= err_multi_q | multi;
      err_spur_q  <= err_spur_q | spur;
    end
  end

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
    arb_client_fsm #(
      .WAIT_MAX(WAIT_MAX),
      .CNT_W   (CNT_W)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req_in[i]),
      .done_i  (done_in[i]),
      .g_i     (g[i]),
      .multi_i (multi),
      .arb_x_o (arb_x[i]),
      .grant_o (grant_out[i]),
      .starve_o(starve[i]),
      .idle_o  (idle[i])
    );
  end

  assign err_multi = err_multi_q;
  assign err_spur  = err_spur_q;

endmodule

// File: tb/tb_arb_client_ctrl.sv
// Randomised bench for arb_client_ctrl against a
// behavioural handshake model.
module tb_arb_client_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] done_in = '0;
  logic [3:0] arb_y = '0;
  logic [3:0] grant_out, arb_x, starve;
  logic       err_multi, err_spur;

  int n_tests = 0;
  int n_fail  = 0;

  arb_client_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .done_in  (done_in),
    .grant_out(grant_out),
    .arb_x    (arb_x),
    .arb_y    (arb_y),
    .err_multi(err_multi),
    .err_spur (err_spur),
    .starve   (starve)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 waiting, 2 owning, 3 releasing
  int         mst [4];
  int         mwait [4];
  logic [3:0] mstarve;
  logic       mmulti, mspur;
  logic [3:0] dly [2];

  function automatic logic [3:0] eg();
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = (mst[i] == 2);
    return v;
  endfunction

  function automatic logic [3:0] ex();
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = (mst[i] == 1 || mst[i] == 2);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mst[i] = 0;
      mwait[i] = 0;
    end
    mstarve = '0;
    mmulti = 0;
    mspur = 0;
    dly[0] = '0;
    dly[1] = '0;
  endtask

  task automatic model_edge();
    logic [3:0] gs;
    bit many;
    gs = dly[1];
    dly[1] = dly[0];
    dly[0] = arb_y;
    many = $countones(gs) > 1;
    if (many) mmulti = 1;
    for (int i = 0; i < 4; i++) begin
      if (mst[i] == 0) begin
        if (gs[i]) mspur = 1;
        if (req_in[i]) begin
          mst[i] = 1;
          mwait[i] = 0;
        end
      end else if (mst[i] == 1) begin
        if (mwait[i] < 255) mwait[i]++;
        if (mwait[i] == 255) mstarve[i] = 1;
        if (gs[i] && !many) mst[i] = 2;
      end else if (mst[i] == 2) begin
        if (done_in[i]) mst[i] = 3;
      end else begin
        if (!gs[i]) mst[i] = 0;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] y);
    @(negedge clk);
    req_in = r;
    done_in = d;
    arb_y = y;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    cycle('0, '0, '0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({grant_out, arb_x, starve, err_multi, err_spur} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset: got %b %b %b %b %b want zeros",
               grant_out, arb_x, starve, err_multi, err_spur);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(4'b0100, '0, '0);
    n_tests++;
    if (arb_x !== 4'b0100 || grant_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_req: arb_x=%b grant=%b want 0100/0000",
               arb_x, grant_out);
    end
    cycle('0, '0, 4'b0100);
    cycle('0, '0, 4'b0100);
    n_tests++;
    if (grant_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_early: grant=%b want 0000", grant_out);
    end
    cycle('0, '0, 4'b0100);
    n_tests++;
    if (grant_out !== 4'b0100 || arb_x !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b arb_x=%b want 0100",
               grant_out, arb_x);
    end
    cycle(4'b0100, 4'b0100, 4'b0100);
    n_tests++;
    if (grant_out !== 4'b0000 || arb_x !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: grant=%b arb_x=%b want 0000",
               grant_out, arb_x);
    end
    for (int k = 0; k < 4; k++) cycle('0, '0, '0);
    cycle(4'b0100, '0, '0);
    n_tests++;
    if (arb_x !== 4'b0100 || err_spur !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rereq: arb_x=%b spur=%b want 0100/0",
               arb_x, err_spur);
    end
  endtask

  task automatic test_contention();
    logic [3:0] pend = 4'b1111;
    do_reset();
    cycle(4'b1111, '0, '0);
    for (int c = 3; c >= 0; c--) begin
      int t = 0;
      while (grant_out[c] !== 1'b1 && t < 20) begin
        cycle('0, '0, 4'(1 << c));
        t++;
        n_tests++;
        if ($countones(grant_out) > 1 || grant_out !== eg()) begin
          n_fail++;
          $display("FAIL contend_onehot: grant=%b want %b",
                   grant_out, eg());
        end
      end
      n_tests++;
      if (t >= 20) begin
        n_fail++;
        $display("FAIL contend_timeout: client %0d grant=%b want set",
                 c, grant_out);
      end
      pend[c] = 0;
      cycle('0, 4'(1 << c), 4'(1 << c));
      n_tests++;
      if (grant_out !== 4'b0000 || arb_x !== pend) begin
        n_fail++;
        $display("FAIL contend_release: grant=%b arb_x=%b want 0000/%b",
                 grant_out, arb_x, pend);
      end
      for (int k = 0; k < 3; k++) cycle('0, '0, '0);
    end
    n_tests++;
    if (err_multi !== 1'b0 || err_spur !== 1'b0 || arb_x !== 4'b0000) begin
      n_fail++;
      $display("FAIL contend_end: multi=%b spur=%b arb_x=%b want 0/0/0000",
               err_multi, err_spur, arb_x);
    end
  endtask

  task automatic test_multi();
    do_reset();
    cycle(4'b0011, '0, '0);
    for (int k = 0; k < 5; k++) cycle('0, '0, 4'b0011);
    n_tests++;
    if (err_multi !== 1'b1 || grant_out !== 4'b0000 || arb_x !== 4'b0011) begin
      n_fail++;
      $display("FAIL multi_flag: multi=%b grant=%b arb_x=%b want 1/0000/0011",
               err_multi, grant_out, arb_x);
    end
    for (int k = 0; k < 3; k++) cycle('0, '0, 4'b0001);
    n_tests++;
    if (grant_out !== 4'b0001 || err_multi !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_recover: grant=%b multi=%b want 0001/1",
               grant_out, err_multi);
    end
  endtask

  task automatic test_spur();
    do_reset();
    for (int k = 0; k < 3; k++) cycle('0, '0, 4'b1000);
    n_tests++;
    if (err_spur !== 1'b1 || grant_out !== 4'b0000 || arb_x !== 4'b0000) begin
      n_fail++;
      $display("FAIL spur: spur=%b grant=%b arb_x=%b want 1/0000/0000",
               err_spur, grant_out, arb_x);
    end
  endtask

  task automatic test_starve();
    do_reset();
    cycle(4'b0010, '0, '0);
    for (int k = 0; k < 254; k++) cycle(4'b0010, '0, '0);
    n_tests++;
    if (starve !== 4'b0000) begin
      n_fail++;
      $display("FAIL starve_early: starve=%b want 0000", starve);
    end
    cycle(4'b0010, '0, '0);
    n_tests++;
    if (starve !== 4'b0010 || arb_x !== 4'b0010) begin
      n_fail++;
      $display("FAIL starve_set: starve=%b arb_x=%b want 0010/0010",
               starve, arb_x);
    end
    for (int k = 0; k < 3; k++) cycle('0, '0, '0);
    n_tests++;
    if (starve !== 4'b0010 || arb_x !== 4'b0010) begin
      n_fail++;
      $display("FAIL starve_hold: starve=%b arb_x=%b want 0010/0010",
               starve, arb_x);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    for (int k = 0; k < 3; k++) cycle('0, '0, 4'b0100);
    cycle(4'b1000, '0, '0);
    for (int k = 0; k < 3; k++) cycle('0, '0, 4'b1000);
    n_tests++;
    if (grant_out !== 4'b1000 || err_spur !== 1'b1) begin
      n_fail++;
      $display("FAIL rmg_setup: grant=%b spur=%b want 1000/1",
               grant_out, err_spur);
    end
    @(negedge clk);
    rst_n = 0;
    cycle('0, '0, 4'b1000);
    n_tests++;
    if ({grant_out, arb_x, starve, err_multi, err_spur} !== 14'd0) begin
      n_fail++;
      $display("FAIL rmg_reset: grant=%b arb_x=%b spur=%b want zeros",
               grant_out, arb_x, err_spur);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    int owner = -1;
    int rr = 0;
    logic [3:0] y;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if (owner >= 0 && !arb_x[owner]) owner = -1;
      if (owner < 0) begin
        for (int k = 0; k < 4; k++)
          if (owner < 0 && arb_x[(rr + k) % 4]) owner = (rr + k) % 4;
        rr = (rr + 1) % 4;
      end
      y = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      if ($urandom_range(0, 39) == 0) y = 4'($urandom_range(0, 15));
      cycle(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), y);
      n_tests++;
      if ({grant_out, arb_x, starve, err_multi, err_spur} !==
          {eg(), ex(), mstarve, mmulti, mspur}) begin
        n_fail++;
        $display("FAIL random[%0d]: g=%b x=%b s=%b m=%b sp=%b want %b %b %b %b %b",
                 n, grant_out, arb_x, starve, err_multi, err_spur,
                 eg(), ex(), mstarve, mmulti, mspur);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_multi();
    test_spur();
    test_starve();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_client_ctrl.md
# arb_client_ctrl

Client-side handshake controller sitting directly downstream of the 4-way mutex arbiter: it turns four client request/done handshakes into the arbiter's X3..X0 request lines and consumes its Y3..Y0 grant lines. It synchronises the grants, delivers a registered, checked, one-hot grant back to each client, holds it until the client releases, and runs a return-to-zero release. It also flags arbiter misbehaviour (multiple grants, spurious grants) and starved clients.

## Interface
Parameters:
- SYNC_STAGES, 2: flops on the incoming grant lines (min 1).
- WAIT_MAX, 255: cycles a client may sit in WAIT before its starve bit sets.
- CNT_W, 8: wait-counter width; WAIT_MAX < 2^CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_in  in  4  client request level, bit i = client i (3..0).
- done_in  in  4  client release pulse/level, bit i = client i.
- grant_out  out  4  registered grant to clients, one-hot or zero.
- arb_x  out  4  request lines to arbiter X3..X0.
- arb_y  in  4  grant lines from arbiter Y3..Y0.
- err_multi  out  1  sticky: >1 synced grant bit seen.
- err_spur  out  1  sticky: synced grant for client in IDLE.
- starve  out  4  sticky per-client wait timeout.

## Operation
- Per-client FSM, states IDLE, WAIT, GRANT, RELEASE; g = synced arb_y, multi = popcount(g) > 1.
- IDLE: arb_x[i]=0. req_in[i]=1 -> WAIT; wait counter cleared.
- WAIT: arb_x[i]=1; counter increments, saturating at WAIT_MAX; on reaching WAIT_MAX set starve[i], stay in WAIT. g[i]=1 and !multi -> GRANT.
- GRANT: arb_x[i]=1, grant_out[i]=1. done_in[i]=1 -> RELEASE. g[i] dropping while in GRANT is ignored (client owns the resource until done).
- RELEASE: arb_x[i]=0, grant_out[i]=0. g[i]=0 -> IDLE.
- multi: err_multi sets; no client may enter GRANT that cycle; clients already in GRANT keep it.
- g[i]=1 while client i is IDLE: err_spur sets; no state change.
- done_in outside GRANT is ignored. req_in deassertion in WAIT does not withdraw; the request completes the handshake.
- Sticky flags and starve clear only on reset.

## Timing
- Reset (rst_n=0 at edge): all FSMs IDLE, counters 0, sync flops 0, all outputs 0 the cycle after.
- req_in[i] high at edge n -> arb_x[i] high after edge n (1 cycle).
- arb_y[i] high at edge m -> g[i] visible after SYNC_STAGES edges; grant_out[i] high one edge later (latency SYNC_STAGES+1).
- done_in[i] at edge k -> grant_out[i] and arb_x[i] low after edge k.
- RELEASE -> IDLE one edge after g[i] observed low; new request accepted in IDLE the following edge (no IDLE bypass).
- done_in and req_in both high in GRANT: done wins.
- Reset mid-grant: all outputs drop after the reset edge, including arb_x, regardless of arbiter state.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package arb_pkg: N_CLIENTS=4; state enum IDLE=2'd0, WAIT=2'd1, GRANT=2'd2, RELEASE=2'd3.
- Sub-module arb_client_fsm (one client: FSM, wait counter, starve bit), instantiated 4x.
- Top holds the grant synchroniser, popcount/multi detect, spurious detect and sticky error flags.

## Test plan
- Single: req_in=4'b0100 -> arb_x=4'b0100 after 1 cycle; arb_y=4'b0100 -> grant_out=4'b0100 after 3 cycles; done_in[2] -> grant_out=0, arb_x=0 next cycle; arb_y=0 -> IDLE.
- Contention: req_in=4'b1111; arbiter model grants 3,2,1,0 in turn -> grant_out always one-hot; each client completes; err_multi=0.
- Multi-grant fault: force arb_y=4'b0011 while clients 0 and 1 WAIT -> err_multi=1, grant_out stays 0; then arb_y=4'b0001 -> grant_out=4'b0001.
- Spurious: all IDLE, arb_y=4'b1000 -> err_spur=1, grant_out=0, arb_x=0.
- Starvation: req_in[1]=1, arb_y held 0 for 256 cycles -> starve=4'b0010 at cycle 255 of WAIT; arb_x[1] stays 1.
- Reset mid-grant: client 3 in GRANT, rst_n=0 one cycle -> grant_out=0, arb_x=0, flags cleared next cycle.
